// File: rtl/ascon_block_pad.sv
// Byte-stream to 64-bit block packer with ASCON-128 0x80 padding.
// Bytes are packed big-endian; the final block of every message carries the pad.
module ascon_block_pad (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    input  logic        i_byte_last,
    input  logic        i_byte_empty,
    output logic        o_byte_ready,
    output logic [63:0] o_data,
    output logic        o_data_valid,
    output logic        o_data_last,
    input  logic        i_data_ready
);
    typedef enum logic [1:0] {FILL, OUT, OUT_PAD} state_t;

    state_t     state;
    logic [2:0] idx;
    logic       pad_pending;
    logic       beat;
    logic       blk_xfer;

    assign beat     = i_byte_valid && o_byte_ready;
    assign blk_xfer = o_data_valid && i_data_ready;

    // Byte position 0 is the most significant byte of the block.
    function automatic logic [63:0] put_byte(input logic [63:0] d,
                                             input logic [2:0]  pos,
                                             input logic [7:0]  b);
        logic [63:0] r;
        r = d;
        for (int k = 0; k < 8; k++) begin
            if (pos == 3'(k)) r[63-8*k -: 8] = b;
        end
        return r;
    endfunction

    // o_data doubles as the assembly buffer, so unwritten bytes are always zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FILL;
            idx          <= 3'd0;
            pad_pending  <= 1'b0;
            o_data       <= 64'd0;
            o_data_valid <= 1'b0;
            o_data_last  <= 1'b0;
            o_byte_ready <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    o_byte_ready <= 1'b1;
                    if (beat) begin
                        if (i_byte_empty) begin
                            if (i_byte_last) begin
                                o_data       <= put_byte(o_data, idx, 8'h80);
                                o_data_last  <= 1'b1;
                                o_data_valid <= 1'b1;
                                o_byte_ready <= 1'b0;
                                state        <= OUT;
                            end
                        end else if (i_byte_last) begin
                            o_data_valid <= 1'b1;
                            o_byte_ready <= 1'b0;
                            state        <= OUT;
                            if (idx == 3'd7) begin
                                o_data      <= put_byte(o_data, idx, i_byte);
                                o_data_last <= 1'b0;
                                pad_pending <= 1'b1;
                            end else begin
                                o_data      <= put_byte(put_byte(o_data, idx, i_byte),
                                                        idx + 3'd1, 8'h80);
                                o_data_last <= 1'b1;
                            end
                        end else begin
                            o_data <= put_byte(o_data, idx, i_byte);
                            if (idx == 3'd7) begin
                                pad_pending  <= 1'b0;
                                o_data_valid <= 1'b1;
                                o_byte_ready <= 1'b0;
                                state        <= OUT;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                    end
                end
                OUT, OUT_PAD: begin
                    if (blk_xfer) begin
                        if (state == OUT && pad_pending) begin
                            o_data      <= 64'h8000_0000_0000_0000;
                            o_data_last <= 1'b1;
                            pad_pending <= 1'b0;
                            state       <= OUT_PAD;
                        end else begin
                            o_data       <= 64'd0;
                            o_data_last  <= 1'b0;
                            o_data_valid <= 1'b0;
                            o_byte_ready <= 1'b1;
                            idx          <= 3'd0;
                            state        <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_block_pad.sv
// Directed bench for ascon_block_pad: vector table of messages plus
// hand-written backpressure and reset sequences.
module tb_ascon_block_pad;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        i_byte_last;
    logic        i_byte_empty;
    logic        o_byte_ready;
    logic [63:0] o_data;
    logic        o_data_valid;
    logic        o_data_last;
    logic        i_data_ready;

    int errors = 0;
    int checks = 0;
    logic [64:0] blkq[$];

    ascon_block_pad dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_byte_last  (i_byte_last),
        .i_byte_empty (i_byte_empty),
        .o_byte_ready (o_byte_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_data_last  (o_data_last),
        .i_data_ready (i_data_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset_n && o_data_valid && i_data_ready) blkq.push_back({o_data_last, o_data});
    end

    typedef struct {
        logic [79:0] msg;
        int          len;
        logic        term_empty;
        int          nblk;
        logic [63:0] exp0;
        logic        last0;
        logic [63:0] exp1;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic send_beat(input logic [7:0] b, input logic l, input logic e);
        int n = 0;
        i_byte       = b;
        i_byte_last  = l;
        i_byte_empty = e;
        i_byte_valid = 1'b1;
        while (!o_byte_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got o_byte_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clock);
        @(negedge clock);
        i_byte_valid = 1'b0;
    endtask

    task automatic wait_blocks(input int n, input string name);
        int c = 0;
        while (blkq.size() < n && c < 40) begin
            @(negedge clock);
            c++;
        end
        repeat (3) @(negedge clock);
        check({name, "_count"}, 64'(blkq.size()), 64'(n));
    endtask

    task automatic check_block(input string name, input logic [63:0] exp, input logic last);
        logic [64:0] b;
        if (blkq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no block expected %h", name, exp);
        end else begin
            b = blkq.pop_front();
            check({name, "_data"}, b[63:0], exp);
            check({name, "_last"}, 64'(b[64]), 64'(last));
        end
    endtask

    initial begin
        logic [63:0] held;
        reset_n      = 1'b0;
        i_byte       = 8'd0;
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        i_byte_empty = 1'b0;
        i_data_ready = 1'b1;

        vecs[0] = '{80'h4142_0000_0000_0000_0000, 2, 1'b0, 1, 64'h4142_8000_0000_0000, 1'b1, 64'd0};
        vecs[1] = '{80'h0102_0304_0506_0708_0000, 8, 1'b0, 2, 64'h0102_0304_0506_0708, 1'b0, 64'h8000_0000_0000_0000};
        vecs[2] = '{80'h0, 0, 1'b1, 1, 64'h8000_0000_0000_0000, 1'b1, 64'd0};
        vecs[3] = '{80'hA0A1_A2A3_A4A5_A6A7_A8A9, 10, 1'b0, 2, 64'hA0A1_A2A3_A4A5_A6A7, 1'b0, 64'hA8A9_8000_0000_0000};
        vecs[4] = '{80'h1011_1213_1415_1600_0000, 7, 1'b0, 1, 64'h1011_1213_1415_1680, 1'b1, 64'd0};
        vecs[5] = '{80'hC1C2_C300_0000_0000_0000, 3, 1'b1, 1, 64'hC1C2_C380_0000_0000, 1'b1, 64'd0};
        vecs[6] = '{80'h0102_0304_0506_0708_0000, 8, 1'b1, 2, 64'h0102_0304_0506_0708, 1'b0, 64'h8000_0000_0000_0000};

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_data", o_data, 64'd0);
        check("rst_valid", 64'(o_data_valid), 64'd0);
        check("rst_last", 64'(o_data_last), 64'd0);
        check("rst_ready", 64'(o_byte_ready), 64'd0);
        reset_n = 1'b1;
        #1 check("ready_before_edge", 64'(o_byte_ready), 64'd0);
        @(negedge clock);
        check("ready_after_edge", 64'(o_byte_ready), 64'd1);

        // Table-driven messages
        for (int v = 0; v < 7; v++) begin
            blkq.delete();
            for (int i = 0; i < vecs[v].len; i++)
                send_beat(vecs[v].msg[79-8*i -: 8], !vecs[v].term_empty && (i == vecs[v].len - 1), 1'b0);
            if (vecs[v].term_empty) send_beat(8'h00, 1'b1, 1'b1);
            wait_blocks(vecs[v].nblk, $sformatf("vec%0d", v));
            check_block($sformatf("vec%0d_b0", v), vecs[v].exp0, vecs[v].last0);
            if (vecs[v].nblk == 2) check_block($sformatf("vec%0d_b1", v), vecs[v].exp1, 1'b1);
        end

        // Empty beat without last is ignored
        blkq.delete();
        send_beat(8'h33, 1'b0, 1'b0);
        send_beat(8'hEE, 1'b0, 1'b1);
        send_beat(8'h44, 1'b1, 1'b0);
        wait_blocks(1, "empty_mid");
        check_block("empty_mid_b0", 64'h3344_8000_0000_0000, 1'b1);

        // Backpressure and one-cycle latency
        blkq.delete();
        i_data_ready = 1'b0;
        send_beat(8'h41, 1'b0, 1'b0);
        send_beat(8'h42, 1'b1, 1'b0);
        check("lat_valid", 64'(o_data_valid), 64'd1);
        held = o_data;
        check("bp_data0", o_data, 64'h4142_8000_0000_0000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("bp_data", o_data, 64'h4142_8000_0000_0000);
            check("bp_last", 64'(o_data_last), 64'd1);
            check("bp_ready", 64'(o_byte_ready), 64'd0);
        end
        i_data_ready = 1'b1;
        wait_blocks(1, "bp");
        check_block("bp_b0", held, 1'b1);
        check("bp_ready_after", 64'(o_byte_ready), 64'd1);

        // Reset mid-fill
        blkq.delete();
        repeat (3) send_beat(8'hFF, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1 check("midfill_rst_data", o_data, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send_beat(8'h11, 1'b1, 1'b0);
        wait_blocks(1, "midfill");
        check_block("midfill_b0", 64'h1180_0000_0000_0000, 1'b1);

        // Reset while holding a full block with pad pending
        blkq.delete();
        i_data_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(8'(i + 1), i == 7, 1'b0);
        check("padrst_hold", o_data, 64'h0102_0304_0506_0708);
        check("padrst_last", 64'(o_data_last), 64'd0);
        #2 reset_n = 1'b0;
        #1 check("padrst_valid_async", 64'(o_data_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        i_data_ready = 1'b1;
        repeat (10) @(negedge clock);
        check("padrst_no_block", 64'(blkq.size()), 64'd0);
        check("padrst_valid", 64'(o_data_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
